// File: rtl/noc_pkg.sv
// Shared NoC router types and constants: flit type encoding, output-channel
// lock states and the default channel sizing.
package noc_pkg;

   localparam int FLIT_W     = 34;
   localparam int BUF_DEPTH  = 4;
   localparam int CREDIT_MAX = 4;

   typedef enum logic [1:0] {
      FLIT_BODY     = 2'b00,
      FLIT_HEAD     = 2'b01,
      FLIT_TAIL     = 2'b10,
      FLIT_HEADTAIL = 2'b11
   } flit_type_e;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } outc_state_e;

   function automatic flit_type_e flit_type(input logic [FLIT_W-1:0] flit);
      return flit_type_e'(flit[FLIT_W-1 -: 2]);
   endfunction

endpackage

// File: rtl/flit_fifo.sv
// Synchronous flit FIFO with registered occupancy count; shared by the router
// input and output channels.
module flit_fifo #(
   parameter int FLIT_W    = 34,
   parameter int BUF_DEPTH = 4,
   localparam int PTR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1,
   localparam int CNT_W    = $clog2(BUF_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [FLIT_W-1:0] din,
   output logic [FLIT_W-1:0] dout,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty
);

   logic [FLIT_W-1:0] mem [BUF_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == CNT_W'(BUF_DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Power-of-2 depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/outputc_tx.sv
// Router output channel transmit side: buffers crossbar flits, holds a
// per-packet wormhole lock and sends downstream under credit flow control.
module outputc_tx #(
   parameter int PORT_N     = 5,
   parameter int PORT_W     = 3,
   parameter int FLIT_W     = noc_pkg::FLIT_W,
   parameter int BUF_DEPTH  = noc_pkg::BUF_DEPTH,
   parameter int CREDIT_MAX = noc_pkg::CREDIT_MAX
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [FLIT_W-1:0] in_flit,
   input  logic [PORT_W-1:0] in_src,
   output logic              rdy_o,
   output logic              lck_o,
   output logic [PORT_W-1:0] lck_owner_o,
   output logic              out_valid,
   output logic [FLIT_W-1:0] out_flit,
   input  logic              credit_i,
   output logic              err_o
);
   import noc_pkg::*;

   localparam int CNT_W  = $clog2(BUF_DEPTH + 1);
   localparam int CRED_W = $clog2(CREDIT_MAX + 1);

   if (PORT_W < $clog2(PORT_N)) begin : g_port_w_check
      $error("PORT_W too narrow for PORT_N");
   end

   outc_state_e       state_q, state_d;
   logic [PORT_W-1:0] owner_q, owner_d;
   flit_type_e        in_type;
   logic              lock_ok;
   logic              accept;
   logic              send;
   logic              credit_ovf;
   logic [CRED_W-1:0] credits_q;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_full;
   logic              fifo_empty;
   logic [FLIT_W-1:0] fifo_dout;

   assign in_type     = flit_type(in_flit);
   assign rdy_o       = (fifo_count < CNT_W'(BUF_DEPTH));
   assign lck_o       = (state_q == LOCKED);
   assign lck_owner_o = owner_q;
   assign accept      = in_valid && rdy_o && lock_ok;
   assign send        = !fifo_empty && (credits_q != '0);
   assign credit_ovf  = credit_i && !send && (credits_q == CRED_W'(CREDIT_MAX));

   flit_fifo #(
      .FLIT_W    (FLIT_W),
      .BUF_DEPTH (BUF_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept && !fifo_full),
      .pop   (send),
      .din   (in_flit),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      lock_ok = 1'b0;
      case (state_q)
         IDLE: begin
            lock_ok = (in_type == FLIT_HEAD) || (in_type == FLIT_HEADTAIL);
            if (in_valid && rdy_o && in_type == FLIT_HEAD) begin
               state_d = LOCKED;
               owner_d = in_src;
            end
         end
         LOCKED: begin
            lock_ok = (in_src == owner_q) &&
                      ((in_type == FLIT_BODY) || (in_type == FLIT_TAIL));
            if (in_valid && rdy_o && lock_ok && in_type == FLIT_TAIL)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         owner_q   <= '0;
         credits_q <= CRED_W'(CREDIT_MAX);
         out_valid <= 1'b0;
         out_flit  <= '0;
         err_o     <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         out_valid <= send;
         if (send) out_flit <= fifo_dout;
         // A returning credit in the same cycle as a send cancels out.
         if (send && !credit_i)
            credits_q <= credits_q - 1'b1;
         else if (!send && credit_i && !credit_ovf)
            credits_q <= credits_q + 1'b1;
         if ((in_valid && !accept) || credit_ovf) err_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_outputc_tx.sv
// Directed vector bench for outputc_tx: table of per-cycle stimulus with
// hand-computed expected outputs, plus a hand-written lock corner sequence.
module tb_outputc_tx;
   import noc_pkg::*;

   localparam int PW = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic [FLIT_W-1:0] in_flit;
   logic [PW-1:0]     in_src;
   logic              credit_i;
   logic              rdy_o;
   logic              lck_o;
   logic [PW-1:0]     lck_owner_o;
   logic              out_valid;
   logic [FLIT_W-1:0] out_flit;
   logic              err_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   outputc_tx #(
      .PORT_N     (5),
      .PORT_W     (PW),
      .FLIT_W     (FLIT_W),
      .BUF_DEPTH  (BUF_DEPTH),
      .CREDIT_MAX (CREDIT_MAX)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_flit     (in_flit),
      .in_src      (in_src),
      .rdy_o       (rdy_o),
      .lck_o       (lck_o),
      .lck_owner_o (lck_owner_o),
      .out_valid   (out_valid),
      .out_flit    (out_flit),
      .credit_i    (credit_i),
      .err_o       (err_o)
   );

   typedef struct {
      logic              rst;
      logic              vld;
      logic [FLIT_W-1:0] flit;
      logic [PW-1:0]     src;
      logic              cred;
      logic              e_rdy;
      logic              e_lck;
      logic [PW-1:0]     e_own;
      logic              e_ov;
      logic [FLIT_W-1:0] e_of;
      logic              e_err;
   } vec_t;

   vec_t vq[$];

   function automatic logic [FLIT_W-1:0] mk(flit_type_e t, logic [31:0] p);
      return {t, p};
   endfunction

   function automatic void add(logic r, logic v, logic [FLIT_W-1:0] f, logic [PW-1:0] s,
                               logic c, logic rdy, logic lck, logic [PW-1:0] own,
                               logic ov, logic [FLIT_W-1:0] of, logic err);
      vec_t x;
      x.rst = r; x.vld = v; x.flit = f; x.src = s; x.cred = c;
      x.e_rdy = rdy; x.e_lck = lck; x.e_own = own; x.e_ov = ov; x.e_of = of; x.e_err = err;
      vq.push_back(x);
   endfunction

   task automatic step(logic r, logic v, logic [FLIT_W-1:0] f, logic [PW-1:0] s, logic c);
      rst = r; in_valid = v; in_flit = f; in_src = s; credit_i = c;
      @(posedge clk);
      #1;
   endtask

   // Owner is only meaningful while the lock is held.
   task automatic check(string nm, logic rdy, logic lck, logic [PW-1:0] own,
                        logic ov, logic [FLIT_W-1:0] of, logic err);
      checks++;
      if (rdy_o !== rdy || lck_o !== lck || (lck && lck_owner_o !== own) ||
          out_valid !== ov || out_flit !== of || err_o !== err) begin
         errors++;
         $display("FAIL %s: got rdy=%b lck=%b own=%0d ov=%b flit=%h err=%b, want rdy=%b lck=%b own=%0d ov=%b flit=%h err=%b",
                  nm, rdy_o, lck_o, lck_owner_o, out_valid, out_flit, err_o,
                  rdy, lck, own, ov, of, err);
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, got running want finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic got;
      rst = 1'b1; in_valid = 1'b0; in_flit = '0; in_src = '0; credit_i = 1'b0;

      // Single HEADTAIL from src 2: appears two cycles later, no lock.
      add(1,0,'0,0,0,                          1,0,0,0,'0,0);
      add(0,1,mk(FLIT_HEADTAIL,32'hA0),2,0,    1,0,0,0,'0,0);
      add(0,0,'0,0,0,                          1,0,0,1,mk(FLIT_HEADTAIL,32'hA0),0);
      add(0,0,'0,0,0,                          1,0,0,0,mk(FLIT_HEADTAIL,32'hA0),0);
      // Four-flit packet from src 1, back to back.
      add(1,0,'0,0,0,                          1,0,0,0,'0,0);
      add(0,1,mk(FLIT_HEAD,32'hB0),1,0,        1,1,1,0,'0,0);
      add(0,1,mk(FLIT_BODY,32'hB1),1,0,        1,1,1,1,mk(FLIT_HEAD,32'hB0),0);
      add(0,1,mk(FLIT_BODY,32'hB2),1,0,        1,1,1,1,mk(FLIT_BODY,32'hB1),0);
      add(0,1,mk(FLIT_TAIL,32'hB3),1,0,        1,0,0,1,mk(FLIT_BODY,32'hB2),0);
      add(0,0,'0,0,0,                          1,0,0,1,mk(FLIT_TAIL,32'hB3),0);
      add(0,0,'0,0,0,                          1,0,0,0,mk(FLIT_TAIL,32'hB3),0);
      // Non-owner BODY while locked by src 1 is dropped; owner's TAIL completes.
      add(1,0,'0,0,0,                          1,0,0,0,'0,0);
      add(0,1,mk(FLIT_HEAD,32'hC0),1,0,        1,1,1,0,'0,0);
      add(0,1,mk(FLIT_BODY,32'hC1),3,0,        1,1,1,1,mk(FLIT_HEAD,32'hC0),1);
      add(0,1,mk(FLIT_TAIL,32'hC2),1,0,        1,0,0,0,mk(FLIT_HEAD,32'hC0),1);
      add(0,0,'0,0,0,                          1,0,0,1,mk(FLIT_TAIL,32'hC2),1);
      add(0,0,'0,0,0,                          1,0,0,0,mk(FLIT_TAIL,32'hC2),1);
      // BODY with no packet open is dropped.
      add(1,0,'0,0,0,                          1,0,0,0,'0,0);
      add(0,1,mk(FLIT_BODY,32'hD0),0,0,        1,0,0,0,'0,1);
      add(0,0,'0,0,0,                          1,0,0,0,'0,1);
      // Credits exhaust after 4 sends; FIFO fills; overflow flit dropped.
      add(1,0,'0,0,0,                          1,0,0,0,'0,0);
      add(0,1,mk(FLIT_HEADTAIL,32'hE0),0,0,    1,0,0,0,'0,0);
      add(0,1,mk(FLIT_HEADTAIL,32'hE1),0,0,    1,0,0,1,mk(FLIT_HEADTAIL,32'hE0),0);
      add(0,1,mk(FLIT_HEADTAIL,32'hE2),0,0,    1,0,0,1,mk(FLIT_HEADTAIL,32'hE1),0);
      add(0,1,mk(FLIT_HEADTAIL,32'hE3),0,0,    1,0,0,1,mk(FLIT_HEADTAIL,32'hE2),0);
      add(0,1,mk(FLIT_HEADTAIL,32'hE4),0,0,    1,0,0,1,mk(FLIT_HEADTAIL,32'hE3),0);
      add(0,1,mk(FLIT_HEADTAIL,32'hE5),0,0,    1,0,0,0,mk(FLIT_HEADTAIL,32'hE3),0);
      add(0,1,mk(FLIT_HEADTAIL,32'hE6),0,0,    1,0,0,0,mk(FLIT_HEADTAIL,32'hE3),0);
      add(0,1,mk(FLIT_HEADTAIL,32'hE7),0,0,    0,0,0,0,mk(FLIT_HEADTAIL,32'hE3),0);
      add(0,1,mk(FLIT_HEADTAIL,32'hE8),0,0,    0,0,0,0,mk(FLIT_HEADTAIL,32'hE3),1);
      add(0,0,'0,0,1,                          0,0,0,0,mk(FLIT_HEADTAIL,32'hE3),1);
      add(0,0,'0,0,1,                          1,0,0,1,mk(FLIT_HEADTAIL,32'hE4),1);
      add(0,0,'0,0,0,                          1,0,0,1,mk(FLIT_HEADTAIL,32'hE5),1);
      add(0,0,'0,0,0,                          1,0,0,0,mk(FLIT_HEADTAIL,32'hE5),1);
      add(0,0,'0,0,0,                          1,0,0,0,mk(FLIT_HEADTAIL,32'hE5),1);
      // Credits held at 2 by concurrent credit returns, then saturate.
      add(1,0,'0,0,0,                          1,0,0,0,'0,0);
      add(0,1,mk(FLIT_HEADTAIL,32'hF0),0,0,    1,0,0,0,'0,0);
      add(0,1,mk(FLIT_HEADTAIL,32'hF1),0,0,    1,0,0,1,mk(FLIT_HEADTAIL,32'hF0),0);
      add(0,1,mk(FLIT_HEADTAIL,32'hF2),0,0,    1,0,0,1,mk(FLIT_HEADTAIL,32'hF1),0);
      add(0,1,mk(FLIT_HEADTAIL,32'hF3),0,1,    1,0,0,1,mk(FLIT_HEADTAIL,32'hF2),0);
      add(0,1,mk(FLIT_HEADTAIL,32'hF4),0,1,    1,0,0,1,mk(FLIT_HEADTAIL,32'hF3),0);
      add(0,0,'0,0,1,                          1,0,0,1,mk(FLIT_HEADTAIL,32'hF4),0);
      add(0,0,'0,0,0,                          1,0,0,0,mk(FLIT_HEADTAIL,32'hF4),0);
      add(0,0,'0,0,1,                          1,0,0,0,mk(FLIT_HEADTAIL,32'hF4),0);
      add(0,0,'0,0,1,                          1,0,0,0,mk(FLIT_HEADTAIL,32'hF4),0);
      add(0,0,'0,0,1,                          1,0,0,0,mk(FLIT_HEADTAIL,32'hF4),1);
      // Lock by src 4, drain credits, leave 3 flits buffered, then reset.
      add(0,1,mk(FLIT_HEAD,32'h60),4,0,        1,1,4,0,mk(FLIT_HEADTAIL,32'hF4),1);
      add(0,1,mk(FLIT_BODY,32'h61),4,0,        1,1,4,1,mk(FLIT_HEAD,32'h60),1);
      add(0,1,mk(FLIT_BODY,32'h62),4,0,        1,1,4,1,mk(FLIT_BODY,32'h61),1);
      add(0,1,mk(FLIT_BODY,32'h63),4,0,        1,1,4,1,mk(FLIT_BODY,32'h62),1);
      add(0,1,mk(FLIT_BODY,32'h64),4,0,        1,1,4,1,mk(FLIT_BODY,32'h63),1);
      add(0,1,mk(FLIT_BODY,32'h65),4,0,        1,1,4,0,mk(FLIT_BODY,32'h63),1);
      add(0,1,mk(FLIT_BODY,32'h66),4,0,        1,1,4,0,mk(FLIT_BODY,32'h63),1);
      add(1,0,'0,0,0,                          1,0,0,0,'0,0);
      add(0,1,mk(FLIT_HEADTAIL,32'h70),0,0,    1,0,0,0,'0,0);
      add(0,1,mk(FLIT_HEADTAIL,32'h71),0,0,    1,0,0,1,mk(FLIT_HEADTAIL,32'h70),0);
      add(0,1,mk(FLIT_HEADTAIL,32'h72),0,0,    1,0,0,1,mk(FLIT_HEADTAIL,32'h71),0);
      add(0,1,mk(FLIT_HEADTAIL,32'h73),0,0,    1,0,0,1,mk(FLIT_HEADTAIL,32'h72),0);
      add(0,1,mk(FLIT_HEADTAIL,32'h74),0,0,    1,0,0,1,mk(FLIT_HEADTAIL,32'h73),0);
      add(0,0,'0,0,0,                          1,0,0,0,mk(FLIT_HEADTAIL,32'h73),0);
      add(0,0,'0,0,0,                          1,0,0,0,mk(FLIT_HEADTAIL,32'h73),0);

      for (int i = 0; i < vq.size(); i++) begin
         step(vq[i].rst, vq[i].vld, vq[i].flit, vq[i].src, vq[i].cred);
         check($sformatf("vec%0d", i), vq[i].e_rdy, vq[i].e_lck, vq[i].e_own,
               vq[i].e_ov, vq[i].e_of, vq[i].e_err);
      end

      // Owner sending HEADTAIL inside its own packet is a protocol error.
      step(1, 0, '0, 0, 0);
      check("hs_reset", 1, 0, 0, 0, '0, 0);
      step(0, 1, mk(FLIT_HEAD, 32'h80), 2, 0);
      check("hs_head", 1, 1, 2, 0, '0, 0);
      step(0, 1, mk(FLIT_HEADTAIL, 32'h81), 2, 0);
      check("hs_owner_ht", 1, 1, 2, 1, mk(FLIT_HEAD, 32'h80), 1);
      step(0, 1, mk(FLIT_TAIL, 32'h82), 2, 0);
      check("hs_tail", 1, 0, 0, 0, mk(FLIT_HEAD, 32'h80), 1);
      got = 1'b0;
      for (int c = 0; c < 5 && !got; c++) begin
         step(0, 0, '0, 0, 0);
         if (out_valid === 1'b1) got = 1'b1;
      end
      checks++;
      if (!got || out_flit !== mk(FLIT_TAIL, 32'h82)) begin
         errors++;
         $display("FAIL hs_tail_out: got seen=%b flit=%h, want seen=1 flit=%h",
                  got, out_flit, mk(FLIT_TAIL, 32'h82));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
